btn_debounce_repeat: RTL and testbench

- Debounces one push-button for the digital-clock time-set controls and generates single-cycle press and auto-repeat pulses.
- Sits directly downstream of the two-stage D_FF synchronizer chain and consumes its already-synchronized button level.
- Drives the hour/minute increment enables of the time-set logic: one pulse per press, plus repeated pulses while the button is held.

---
 rtl/btn_debounce_repeat_pkg.sv | 16 +
 rtl/btn_debounce_repeat_tick_counter.sv | 33 +++
 rtl/btn_debounce_repeat.sv | 142 ++++++++++++++
 tb/tb_btn_debounce_repeat.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_repeat_pkg.sv
// Shared state encoding and default timing for the time-set push-button debouncers.
package btn_debounce_repeat_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_DB_PRESS = 3'd1;
    localparam state_t ST_PRESSED  = 3'd2;
    localparam state_t ST_REPEAT   = 3'd3;
    localparam state_t ST_DB_REL   = 3'd4;

    localparam int unsigned DB_TICKS_DEF   = 20;
    localparam int unsigned HOLD_TICKS_DEF = 500;
    localparam int unsigned RPT_TICKS_DEF  = 100;

endpackage

// File: rtl/btn_debounce_repeat_tick_counter.sv
// Saturating tick counter with synchronous clear; o_term flags the enabled tick that
// brings the count up to i_limit.
module btn_debounce_repeat_tick_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_next;

    // One extra bit so the compare stays correct even when r_cnt sits at saturation.
    assign w_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign o_term = i_en && (w_next >= {1'b0, i_limit});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_debounce_repeat.sv
// Push-button debouncer producing single-cycle press and auto-repeat pulses for the
// time-set controls; consumes an already-synchronized button level.
module btn_debounce_repeat
    import btn_debounce_repeat_pkg::*;
#(
    parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int unsigned RPT_TICKS  = RPT_TICKS_DEF,
    parameter int unsigned CNT_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_sync,
    output logic btn_level,
    output logic press_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DB_TICKS);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(RPT_TICKS);

    state_t           r_state, w_state_d;
    logic             r_btn_level, w_btn_level_d;
    logic             r_press, w_press_d;
    logic             r_repeat, w_repeat_d;
    logic             r_held, w_held_d;
    logic             w_clr, w_en, w_term;
    logic [CNT_W-1:0] w_limit;

    // Counting condition and terminal value depend on state only, never on w_term.
    always_comb begin
        w_limit = DB_LIM;
        w_en    = 1'b0;
        case (r_state)
            ST_DB_PRESS: begin w_limit = DB_LIM;   w_en = tick &  btn_sync; end
            ST_PRESSED:  begin w_limit = HOLD_LIM; w_en = tick &  btn_sync; end
            ST_REPEAT:   begin w_limit = RPT_LIM;  w_en = tick &  btn_sync; end
            ST_DB_REL:   begin w_limit = DB_LIM;   w_en = tick & ~btn_sync; end
            default:     ;
        endcase
    end

    btn_debounce_repeat_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_term  (w_term)
    );

    // A btn_sync change is tested before the terminal count so it always wins.
    always_comb begin
        w_state_d     = r_state;
        w_clr         = 1'b0;
        w_btn_level_d = r_btn_level;
        w_held_d      = r_held;
        w_press_d     = 1'b0;
        w_repeat_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (btn_sync) w_state_d = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (!btn_sync) begin
                    w_state_d = ST_IDLE;
                    w_clr     = 1'b1;
                end else if (w_term) begin
                    w_state_d     = ST_PRESSED;
                    w_clr         = 1'b1;
                    w_btn_level_d = 1'b1;
                    w_press_d     = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    w_state_d = ST_DB_REL;
                    w_clr     = 1'b1;
                end else if (w_term) begin
                    w_state_d  = ST_REPEAT;
                    w_clr      = 1'b1;
                    w_held_d   = 1'b1;
                    w_repeat_d = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!btn_sync) begin
                    w_state_d = ST_DB_REL;
                    w_clr     = 1'b1;
                    w_held_d  = 1'b0;
                end else if (w_term) begin
                    w_clr      = 1'b1;
                    w_repeat_d = 1'b1;
                end
            end
            ST_DB_REL: begin
                if (btn_sync) begin
                    w_state_d = ST_PRESSED;
                    w_clr     = 1'b1;
                end else if (w_term) begin
                    w_state_d     = ST_IDLE;
                    w_clr         = 1'b1;
                    w_btn_level_d = 1'b0;
                end
            end
            default: begin
                w_state_d     = ST_IDLE;
                w_clr         = 1'b1;
                w_btn_level_d = 1'b0;
                w_held_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_btn_level <= 1'b0;
            r_press     <= 1'b0;
            r_repeat    <= 1'b0;
            r_held      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_btn_level <= w_btn_level_d;
            r_press     <= w_press_d;
            r_repeat    <= w_repeat_d;
            r_held      <= w_held_d;
        end
    end

    assign btn_level    = r_btn_level;
    assign press_pulse  = r_press;
    assign repeat_pulse = r_repeat;
    assign held         = r_held;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench: directed scenarios plus randomized button/tick traffic against a
// run-length reference model of the debounce and auto-repeat rules.
module tb_btn_debounce_repeat;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rst, tick, btn_sync;
    logic btn_level, press_pulse, repeat_pulse, held;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: run lengths of disagreement and of held-agreement ticks.
    logic m_level, m_held, m_press, m_rpt, m_dis;
    int   m_run, m_since;

    btn_debounce_repeat #(
        .DB_TICKS   (DB),
        .HOLD_TICKS (HOLD),
        .RPT_TICKS  (RPT),
        .CNT_W      (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn_sync     (btn_sync),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_held = 0; m_press = 0; m_rpt = 0; m_dis = 0;
        m_run = 0; m_since = 0;
    endtask

    task automatic model_step(input logic b, input logic t);
        m_press = 0;
        m_rpt   = 0;
        if (b != m_level) begin
            if (!m_dis) begin
                m_dis = 1; m_run = 0; m_held = 0;
            end else if (t) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = b; m_dis = 0; m_since = 0; m_press = b;
                end
            end
        end else if (m_dis) begin
            m_dis = 0; m_since = 0;
        end else if (m_level && t) begin
            m_since++;
            if (m_since >= HOLD && ((m_since - HOLD) % RPT) == 0) m_rpt = 1;
            m_held = (m_since >= HOLD);
        end
    endtask

    task automatic step(input logic b, input logic t);
        btn_sync = b;
        tick     = t;
        @(posedge clk);
        if (rst) model_step(b, t);
        else     model_reset();
        #1;
        cyc++;
        check("btn_level",    btn_level,    m_level);
        check("press_pulse",  press_pulse,  m_press);
        check("repeat_pulse", repeat_pulse, m_rpt);
        check("held",         held,         m_held);
    endtask

    int first, cnt, n_rpt;
    int rpt_q[$];
    logic rb, rt;
    int left;

    initial begin
        rst = 1'b0; btn_sync = 1'b1; tick = 1'b1;
        model_reset();

        // Reset held with the button pressed, then latency to the first press.
        repeat (5) step(1, 1);
        rst = 1'b1;
        cyc = 0; first = -1;
        for (int i = 0; i < 8; i++) begin
            step(1, 1);
            if (press_pulse && first < 0) first = cyc;
        end
        check("rst_press_latency", first, 5);
        repeat (8) step(0, 1);

        // Bounce: never stable for DB ticks.
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (3) begin step(1, 1); cnt += press_pulse + btn_level; end
            step(0, 1);
            cnt += press_pulse + btn_level;
        end
        check("bounce_activity", cnt, 0);
        repeat (2) step(0, 1);

        // Clean press and release.
        cyc = 0; first = -1; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1);
            if (press_pulse) begin cnt++; if (first < 0) first = cyc; end
        end
        check("clean_press_at", first, 5);
        check("clean_press_cnt", cnt, 1);
        check("clean_level", btn_level, 1);
        cyc = 0; first = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            cnt += press_pulse + repeat_pulse;
            if (!btn_level && first < 0) first = cyc;
        end
        check("release_level_at", first, 5);
        check("release_pulses", cnt, 0);

        // Auto-repeat over 30 clocks.
        cyc = 0; first = -1; rpt_q.delete();
        for (int i = 0; i < 30; i++) begin
            step(1, 1);
            if (press_pulse && first < 0) first = cyc;
            if (repeat_pulse) rpt_q.push_back(cyc);
        end
        check("auto_press_at", first, 5);
        n_rpt = rpt_q.size();
        check("auto_rpt_count", n_rpt, 6);
        for (int i = 0; i < n_rpt && i < 6; i++) check("auto_rpt_at", rpt_q[i], 15 + 3 * i);
        check("auto_held", held, 1);

        // Release glitch in REPEAT: held drops, repeat restarts from the hold interval.
        cnt = 0;
        repeat (2) begin step(0, 1); cnt += press_pulse; end
        check("glitch_held", held, 0);
        cyc = 0; first = -1;
        for (int i = 0; i < 15; i++) begin
            step(1, 1);
            cnt += press_pulse;
            if (repeat_pulse && first < 0) first = cyc;
        end
        check("glitch_press_cnt", cnt, 0);
        check("glitch_next_rpt_at", first, 11);

        // Asynchronous reset between edges while in REPEAT.
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_level", btn_level, 0);
        check("async_press", press_pulse, 0);
        check("async_rpt", repeat_pulse, 0);
        check("async_held", held, 0);
        step(0, 1);
        rst = 1'b1;
        repeat (3) step(0, 1);
        repeat (6) step(1, 1);
        repeat (8) step(0, 1);

        // Randomized traffic, with sparse ticks and occasional async resets.
        left = 0; rb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                rb   = ~rb;
                left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
            end
            left--;
            rt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b0;
                #1 model_reset();
                check("rand_async_out", {btn_level, press_pulse, repeat_pulse, held}, 0);
                step(rb, rt);
                rst = 1'b1;
            end else begin
                step(rb, rt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
